// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channel: one producer (EX or MEM stage) pushing
// destination-register writes into the arbiter with a valid/ready handshake.
//   valid  producer -> arbiter  request present
//   ready  arbiter  -> producer FIFO can accept this cycle
//   addr   producer -> arbiter  destination register x[addr]
//   data   producer -> arbiter  writeback value
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two writeback sources (EX results, MEM
// load data) each feed a private FIFO; one FIFO head per cycle is granted onto
// the registered register-file write port.
//
// Ports:
//   clk, arstn      clock / asynchronous active-low reset
//   ex, mem         writeback request channels (slave side)
//   rf_writeEn      registered write enable
//   rf_writeAddr    registered write address (holds when no grant)
//   rf_writeData    registered write data (holds when no grant)
//   pending         bit i set while a write to x[i] is queued or on rf_*
//   idle            both FIFOs empty and rf_writeEn low
//
// Build option: WB_ARB_ROUND_ROBIN_EN selects round-robin grant; without it
// MEM has fixed priority over EX.

// Per-source FIFO with pointer+wrap-bit full/empty and a pending bitmap of
// every queued destination register.
module regfile_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            arstn,
    input  logic            push,
    input  logic [4:0]      push_addr,
    input  logic [XLEN-1:0] push_data,
    input  logic            pop,
    output logic [4:0]      head_addr,
    output logic [XLEN-1:0] head_data,
    output logic            empty,
    output logic            full,
    output logic [31:0]     pend
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic [4:0]      addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign cnt   = wr_ptr - rd_ptr;

    assign head_addr = addr_q[rd_ptr[AW-1:0]];
    assign head_data = data_q[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr[AW-1:0]] <= push_addr;
            data_q[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Slot (rd + j) is live when j < occupancy.
    always_comb begin
        pend = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((AW+1)'(j) < cnt)
                pend[addr_q[rd_ptr[AW-1:0] + AW'(j)]] = 1'b1;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                clk,
    input  logic                arstn,
    regfile_wb_arbiter_if.slave ex,
    regfile_wb_arbiter_if.slave mem,
    output logic                rf_writeEn,
    output logic [4:0]          rf_writeAddr,
    output logic [XLEN-1:0]     rf_writeData,
    output logic [31:0]         pending,
    output logic                idle
);
    localparam int NSRC = 2;   // index 0 = EX, 1 = MEM

    logic                      alive;
    logic [NSRC-1:0]           in_valid, in_ready, push, pop, empty, full;
    logic [NSRC-1:0][4:0]      in_addr, head_addr;
    logic [NSRC-1:0][XLEN-1:0] in_data, head_data;
    logic [NSRC-1:0][31:0]     src_pend;
    logic [31:0]               rf_pend;

    assign in_valid = {mem.valid, ex.valid};
    assign in_addr  = {mem.addr,  ex.addr};
    assign in_data  = {mem.data,  ex.data};
    assign ex.ready  = in_ready[0];
    assign mem.ready = in_ready[1];

    // Holds ready low through reset and releases it one edge later, so ready
    // comes purely from flops and never from arstn combinationally.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    generate
        for (genvar s = 0; s < NSRC; s++) begin : g_src
            assign in_ready[s] = alive && !full[s];
            // x0 writes complete the handshake but are dropped here.
            assign push[s] = in_valid[s] && in_ready[s] && (in_addr[s] != 5'd0);

            regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
                .clk       (clk),
                .arstn     (arstn),
                .push      (push[s]),
                .push_addr (in_addr[s]),
                .push_data (in_data[s]),
                .pop       (pop[s]),
                .head_addr (head_addr[s]),
                .head_data (head_data[s]),
                .empty     (empty[s]),
                .full      (full[s]),
                .pend      (src_pend[s])
            );
        end
    endgenerate

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_mem;   // 1 = MEM granted last; reset value makes EX win first

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn)      last_mem <= 1'b1;
        else if (pop[0]) last_mem <= 1'b0;
        else if (pop[1]) last_mem <= 1'b1;
    end

    always_comb begin
        pop = '0;
        if (!empty[0] && !empty[1]) begin
            if (last_mem) pop[0] = 1'b1;
            else          pop[1] = 1'b1;
        end else if (!empty[0]) begin
            pop[0] = 1'b1;
        end else if (!empty[1]) begin
            pop[1] = 1'b1;
        end
    end
`else
    // MEM always wins; EX drains only when MEM is empty.
    always_comb begin
        pop = '0;
        if (!empty[1])      pop[1] = 1'b1;
        else if (!empty[0]) pop[0] = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            rf_writeEn   <= 1'b0;
            rf_writeAddr <= '0;
            rf_writeData <= '0;
        end else if (pop[1]) begin
            rf_writeEn   <= 1'b1;
            rf_writeAddr <= head_addr[1];
            rf_writeData <= head_data[1];
        end else if (pop[0]) begin
            rf_writeEn   <= 1'b1;
            rf_writeAddr <= head_addr[0];
            rf_writeData <= head_data[0];
        end else begin
            rf_writeEn   <= 1'b0;
        end
    end

    always_comb begin
        rf_pend = '0;
        if (rf_writeEn) rf_pend[rf_writeAddr] = 1'b1;
    end

    assign pending = (src_pend[0] | src_pend[1] | rf_pend) & 32'hFFFF_FFFE;
    assign idle    = empty[0] && empty[1] && !rf_writeEn;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, x0 discard,
// reset with queued traffic, contention, same-register ordering, backpressure.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        arstn;
    logic        rf_writeEn;
    logic [4:0]  rf_writeAddr;
    logic [31:0] rf_writeData;
    logic [31:0] pending;
    logic        idle;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter_if #(.XLEN(32)) ex_if ();
    regfile_wb_arbiter_if #(.XLEN(32)) mem_if ();

    regfile_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .ex           (ex_if),
        .mem          (mem_if),
        .rf_writeEn   (rf_writeEn),
        .rf_writeAddr (rf_writeAddr),
        .rf_writeData (rf_writeData),
        .pending      (pending),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  wq[$];
    logic mon_en  = 1'b0;
    logic ex_drop = 1'b0;

    always @(negedge clk) begin
        if (mon_en && rf_writeEn) wq.push_back('{a: rf_writeAddr, d: rf_writeData});
        if (mon_en && ex_if.valid && !ex_if.ready) ex_drop <= 1'b1;
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam logic [4:0]  FIRST_A = 5'd1;
    localparam logic [31:0] FIRST_D = 32'hA;
    localparam logic [4:0]  SECOND_A = 5'd2;
    localparam logic [31:0] SECOND_D = 32'hB;
`else
    localparam logic [4:0]  FIRST_A = 5'd2;
    localparam logic [31:0] FIRST_D = 32'hB;
    localparam logic [4:0]  SECOND_A = 5'd1;
    localparam logic [31:0] SECOND_D = 32'hA;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ex(input logic [4:0] a, input logic [31:0] d);
        int   n;
        logic acc;
        n = 0;
        ex_if.valid = 1'b1; ex_if.addr = a; ex_if.data = d;
        do begin
            acc = ex_if.ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("ex_push_timeout", 32'(acc), 32'd1);
    endtask

    task automatic push_mem(input logic [4:0] a, input logic [31:0] d);
        int   n;
        logic acc;
        n = 0;
        mem_if.valid = 1'b1; mem_if.addr = a; mem_if.data = d;
        do begin
            acc = mem_if.ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("mem_push_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ne, nm, n;
        arstn = 1'b0;
        ex_if.valid = 1'b0;  ex_if.addr = '0;  ex_if.data = '0;
        mem_if.valid = 1'b0; mem_if.addr = '0; mem_if.data = '0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_we",     32'(rf_writeEn), 32'd0);
        chk("rst_addr",   32'(rf_writeAddr), 32'd0);
        chk("rst_data",   rf_writeData, 32'd0);
        chk("rst_pend",   pending, 32'd0);
        chk("rst_idle",   32'(idle), 32'd1);
        chk("rst_exrdy",  32'(ex_if.ready), 32'd0);
        chk("rst_memrdy", 32'(mem_if.ready), 32'd0);
        arstn = 1'b1;
        @(negedge clk);
        chk("rel_exrdy",  32'(ex_if.ready), 32'd1);
        chk("rel_memrdy", 32'(mem_if.ready), 32'd1);

        // single write x3 = DEADBEEF
        ex_if.valid = 1'b1; ex_if.addr = 5'd3; ex_if.data = 32'hDEAD_BEEF;
        @(negedge clk);
        ex_if.valid = 1'b0;
        chk("sw_we_k",   32'(rf_writeEn), 32'd0);
        chk("sw_pend_k", pending, 32'h8);
        chk("sw_idle_k", 32'(idle), 32'd0);
        @(negedge clk);
        chk("sw_we",   32'(rf_writeEn), 32'd1);
        chk("sw_addr", 32'(rf_writeAddr), 32'd3);
        chk("sw_data", rf_writeData, 32'hDEAD_BEEF);
        chk("sw_pend", pending, 32'h8);
        @(negedge clk);
        chk("sw_we_off",  32'(rf_writeEn), 32'd0);
        chk("sw_hold",    32'(rf_writeAddr), 32'd3);
        chk("sw_pend_off", pending, 32'd0);
        chk("sw_idle",    32'(idle), 32'd1);

        // x0 discard
        mem_if.valid = 1'b1; mem_if.addr = 5'd0; mem_if.data = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_if.valid = 1'b0;
        chk("x0_rdy",  32'(mem_if.ready), 32'd1);
        chk("x0_pend", pending, 32'd0);
        chk("x0_we",   32'(rf_writeEn), 32'd0);
        chk("x0_idle", 32'(idle), 32'd1);
        @(negedge clk);
        chk("x0_we2",  32'(rf_writeEn), 32'd0);
        chk("x0_pend2", pending, 32'd0);

        // reset with traffic queued
        ex_if.valid = 1'b1;  ex_if.addr = 5'd5;  ex_if.data = 32'h11;
        mem_if.valid = 1'b1; mem_if.addr = 5'd6; mem_if.data = 32'h22;
        @(negedge clk);
        ex_if.valid = 1'b0; mem_if.valid = 1'b0;
        chk("rq_pend_pre", pending, 32'h60);
        arstn = 1'b0;
        #1;
        chk("rq_we",   32'(rf_writeEn), 32'd0);
        chk("rq_pend", pending, 32'd0);
        chk("rq_idle", 32'(idle), 32'd1);
        chk("rq_rdy",  32'(ex_if.ready), 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        chk("rq_we2",   32'(rf_writeEn), 32'd0);
        chk("rq_pend2", pending, 32'd0);
        chk("rq_idle2", 32'(idle), 32'd1);
        chk("rq_rdy2",  32'(mem_if.ready), 32'd1);
        @(negedge clk);
        chk("rq_we3",   32'(rf_writeEn), 32'd0);

        // contention: first contention after reset
        ex_if.valid = 1'b1;  ex_if.addr = 5'd1;  ex_if.data = 32'hA;
        mem_if.valid = 1'b1; mem_if.addr = 5'd2; mem_if.data = 32'hB;
        @(negedge clk);
        ex_if.valid = 1'b0; mem_if.valid = 1'b0;
        chk("ct_pend", pending, 32'h6);
        @(negedge clk);
        chk("ct_we1",   32'(rf_writeEn), 32'd1);
        chk("ct_addr1", 32'(rf_writeAddr), 32'(FIRST_A));
        chk("ct_data1", rf_writeData, FIRST_D);
        @(negedge clk);
        chk("ct_we2",   32'(rf_writeEn), 32'd1);
        chk("ct_addr2", 32'(rf_writeAddr), 32'(SECOND_A));
        chk("ct_data2", rf_writeData, SECOND_D);
        @(negedge clk);
        chk("ct_idle",  32'(idle), 32'd1);

        // same-register ordering x7 = 1 then 2
        ex_if.valid = 1'b1; ex_if.addr = 5'd7; ex_if.data = 32'd1;
        @(negedge clk);
        ex_if.data = 32'd2;
        @(negedge clk);
        ex_if.valid = 1'b0;
        chk("sr_addr1", 32'(rf_writeAddr), 32'd7);
        chk("sr_data1", rf_writeData, 32'd1);
        chk("sr_pend1", pending, 32'h80);
        @(negedge clk);
        chk("sr_we2",   32'(rf_writeEn), 32'd1);
        chk("sr_addr2", 32'(rf_writeAddr), 32'd7);
        chk("sr_data2", rf_writeData, 32'd2);
        chk("sr_pend2", pending, 32'h80);
        @(negedge clk);
        chk("sr_we3",   32'(rf_writeEn), 32'd0);
        chk("sr_pend3", pending, 32'd0);

        // backpressure: 6 EX writes against 4 back-to-back MEM writes
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) push_ex(5'(8 + i), 32'(32'h108 + i));
                ex_if.valid = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) push_mem(5'(20 + i), 32'(32'h214 + i));
                mem_if.valid = 1'b0;
            end
        join
        n = 0;
        while (!idle && n < 50) begin
            @(negedge clk);
            n++;
        end
        mon_en = 1'b0;
        chk("bp_idle",    32'(idle), 32'd1);
        chk("bp_drop",    32'(ex_drop), 32'd1);
        chk("bp_count",   32'(wq.size()), 32'd10);
        ne = 0; nm = 0;
        foreach (wq[i]) begin
            if (wq[i].a >= 5'd20) begin
                chk("bp_mem_addr", 32'(wq[i].a), 32'(20 + nm));
                chk("bp_mem_data", wq[i].d, 32'(32'h214 + nm));
                nm++;
            end else begin
                chk("bp_ex_addr", 32'(wq[i].a), 32'(8 + ne));
                chk("bp_ex_data", wq[i].d, 32'(32'h108 + ne));
                ne++;
            end
        end
        chk("bp_ex_n",  32'(ne), 32'd6);
        chk("bp_mem_n", 32'(nm), 32'd4);
        chk("bp_pend",  pending, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
